// File: rtl/centroid_pkg.sv
// Shared widths, FSM encoding and divider latency for the centroid tracker.
// Defaults describe the 64x64 configuration.
package centroid_pkg;

  localparam int DEF_COORD_W = 11;
  localparam int DEF_AREA_W  = 20;
  localparam int DEF_MOM_W   = 32;
  // The restoring divider retires one quotient bit per clock.
  localparam int DIV_LAT     = DEF_MOM_W;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/centroid_tracker_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// done pulses exactly MOM_W cycles after an accepted start.
module seq_divider
  import centroid_pkg::*;
#(
  parameter int MOM_W = DEF_MOM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MOM_W-1:0] dividend,
  input  logic [MOM_W-1:0] divisor,
  output logic [MOM_W-1:0] quotient,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(MOM_W) + 1;

  logic [MOM_W-1:0] rem_q, div_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, ge;
  logic [MOM_W-1:0] src_rem, src_q, src_d, rem_nxt, q_nxt;
  logic [MOM_W:0]   rem_sh, diff;

  assign accept = start & ~busy;

  // The first bit is retired on the start edge itself, so the start cycle
  // reads its operands straight from the ports.
  always_comb begin
    src_rem = accept ? '0 : rem_q;
    src_q   = accept ? dividend : quotient;
    src_d   = accept ? divisor : div_q;
    rem_sh  = {src_rem, src_q[MOM_W-1]};
    diff    = rem_sh - {1'b0, src_d};
    ge      = rem_sh >= {1'b0, src_d};
    rem_nxt = ge ? diff[MOM_W-1:0] : rem_sh[MOM_W-1:0];
    q_nxt   = {src_q[MOM_W-2:0], ge};
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        quotient <= q_nxt;
        rem_q    <= rem_nxt;
        div_q    <= divisor;
        cnt      <= CNT_W'(1);
        busy     <= 1'b1;
      end else if (busy) begin
        quotient <= q_nxt;
        rem_q    <= rem_nxt;
        cnt      <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(MOM_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/centroid_tracker.sv
// Binary-mask centroid: accumulates area, first moments and bounding box per
// frame, divides at end of frame and reports with a one-cycle valid strobe.
module centroid_tracker
  import centroid_pkg::*;
#(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int COORD_W  = DEF_COORD_W,
  parameter int AREA_W   = DEF_AREA_W,
  parameter int MOM_W    = DEF_MOM_W,
  parameter int MIN_AREA = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de_in,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic               mask,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [AREA_W-1:0]  area,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic               found,
  output logic               result_valid,
  output logic               frame_overrun
);

  state_t             state, state_nxt;
  logic               prev_vsync, eof, hit;
  logic [COORD_W-1:0] x_pos, y_pos;
  logic [AREA_W-1:0]  m00, snap_m00;
  logic [MOM_W-1:0]   m10, m01, snap_m10, snap_m01;
  logic [COORD_W-1:0] bx_min, bx_max, by_min, by_max;
  logic [COORD_W-1:0] sx_min, sx_max, sy_min, sy_max;
  logic               start_div, load_out, found_n;
  logic [MOM_W-1:0]   quot_x, quot_y;
  logic               busy_x, busy_y, done_x, done_y;
  logic               unused_sigs;

  assign eof = v_sync_in & ~prev_vsync;
  assign hit = de_in & mask & ~v_sync_in;
  assign unused_sigs = ^{h_sync_in, busy_x, busy_y,
                         quot_x[MOM_W-1:COORD_W], quot_y[MOM_W-1:COORD_W]};

  always_ff @(posedge clk) begin
    if (rst || v_sync_in) begin
      x_pos <= '0;
      y_pos <= '0;
    end else if (de_in) begin
      if (x_pos == COORD_W'(IMG_W - 1)) begin
        x_pos <= '0;
        y_pos <= (y_pos == COORD_W'(IMG_H - 1)) ? '0 : y_pos + COORD_W'(1);
      end else begin
        x_pos <= x_pos + COORD_W'(1);
      end
    end
  end

  // Accumulators restart on every vsync edge; whether the frame is kept
  // depends only on the FSM being free to take the snapshot.
  always_ff @(posedge clk) begin
    if (rst || eof) begin
      m00    <= '0;
      m10    <= '0;
      m01    <= '0;
      bx_min <= '1;
      by_min <= '1;
      bx_max <= '0;
      by_max <= '0;
    end else if (hit) begin
      m00    <= m00 + AREA_W'(1);
      m10    <= m10 + MOM_W'(x_pos);
      m01    <= m01 + MOM_W'(y_pos);
      bx_min <= (x_pos < bx_min) ? x_pos : bx_min;
      bx_max <= (x_pos > bx_max) ? x_pos : bx_max;
      by_min <= (y_pos < by_min) ? y_pos : by_min;
      by_max <= (y_pos > by_max) ? y_pos : by_max;
    end
  end

  // An empty frame snapshots a zero bounding box rather than the idle trackers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vsync <= 1'b0;
      snap_m00   <= '0;
      snap_m10   <= '0;
      snap_m01   <= '0;
      {sx_min, sx_max, sy_min, sy_max} <= '0;
      frame_overrun <= 1'b0;
    end else begin
      prev_vsync    <= v_sync_in;
      frame_overrun <= eof && (state != IDLE);
      if (eof && state == IDLE) begin
        snap_m00 <= m00;
        snap_m10 <= m10;
        snap_m01 <= m01;
        if (m00 == '0) {sx_min, sx_max, sy_min, sy_max} <= '0;
        else           {sx_min, sx_max, sy_min, sy_max} <= {bx_min, bx_max, by_min, by_max};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    start_div = 1'b0;
    load_out  = 1'b0;
    found_n   = 1'b0;
    case (state)
      IDLE:  if (eof) state_nxt = CHECK;
      CHECK: begin
        if (snap_m00 >= AREA_W'(MIN_AREA) && snap_m00 != '0) begin
          start_div = 1'b1;
          state_nxt = DIV;
        end else begin
          load_out  = 1'b1;
          state_nxt = DONE;
        end
      end
      DIV: begin
        if (done_x && done_y) begin
          load_out  = 1'b1;
          found_n   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  seq_divider #(.MOM_W(MOM_W)) u_div_x (
    .clk(clk), .rst(rst), .start(start_div), .dividend(snap_m10),
    .divisor(MOM_W'(snap_m00)), .quotient(quot_x), .busy(busy_x), .done(done_x)
  );

  seq_divider #(.MOM_W(MOM_W)) u_div_y (
    .clk(clk), .rst(rst), .start(start_div), .dividend(snap_m01),
    .divisor(MOM_W'(snap_m00)), .quotient(quot_y), .busy(busy_y), .done(done_y)
  );

  // Outputs load on the edge into DONE so they are stable while result_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      area <= '0;
      {x_min, x_max, y_min, y_max} <= '0;
      found <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= load_out;
      if (load_out) begin
        area  <= snap_m00;
        {x_min, x_max, y_min, y_max} <= {sx_min, sx_max, sy_min, sy_max};
        found <= found_n;
        if (found_n) begin
          x <= quot_x[COORD_W-1:0];
          y <= quot_y[COORD_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_centroid_tracker.sv
// Randomised frame stimulus for centroid_tracker, checked against a
// pixel-array reference model of area, moments, bounding box and latency.
module tb_centroid_tracker;

  localparam int W = 64, H = 64, CW = 11, AW = 20;
  localparam int LAT_OBJ = 34, LAT_EMPTY = 2, BUDGET = 60;

  logic clk = 1'b0;
  logic rst, de_in, h_sync_in, v_sync_in, mask;
  logic [CW-1:0] x, y, x_min, x_max, y_min, y_max;
  logic [AW-1:0] area;
  logic found, result_valid, frame_overrun;
  logic [CW-1:0] x_4, y_4, x_min_4, x_max_4, y_min_4, y_max_4;
  logic [AW-1:0] area_4;
  logic found_4, result_valid_4, frame_overrun_4;

  always #5 clk = ~clk;

  centroid_tracker dut (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .mask(mask), .x(x), .y(y), .area(area), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max), .found(found), .result_valid(result_valid),
    .frame_overrun(frame_overrun)
  );

  centroid_tracker #(.MIN_AREA(4)) dut4 (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .mask(mask), .x(x_4), .y(y_4), .area(area_4), .x_min(x_min_4), .x_max(x_max_4),
    .y_min(y_min_4), .y_max(y_max_4), .found(found_4), .result_valid(result_valid_4),
    .frame_overrun(frame_overrun_4)
  );

  int total = 0, bad = 0;
  bit pix [H][W];

  // Reference model state; m_x/m_y persist across frames like the outputs.
  int m_area, m_sx, m_sy, m_xmin, m_xmax, m_ymin, m_ymax, m_x = 0, m_y = 0;
  bit m_found;

  // Observations from the last run_frame.
  int obs_lat, obs_rv, obs_ovr_k, obs_ovr_n, lat4, area4;
  bit found4;
  logic [CW-1:0] o_x, o_y, o_xmin, o_xmax, o_ymin, o_ymax;
  logic [AW-1:0] o_area;
  logic o_found;
  logic [6*CW+AW+3:0] end_outs;

  task automatic clear_pix();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[r][c] = 1'b0;
  endtask

  task automatic model_frame();
    m_area = 0; m_sx = 0; m_sy = 0;
    m_xmin = W; m_xmax = -1; m_ymin = H; m_ymax = -1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (pix[r][c]) begin
          m_area++; m_sx += c; m_sy += r;
          if (c < m_xmin) m_xmin = c;
          if (c > m_xmax) m_xmax = c;
          if (r < m_ymin) m_ymin = r;
          if (r > m_ymax) m_ymax = r;
        end
    if (m_area == 0) begin
      m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    end
    m_found = (m_area >= 1);
    if (m_found) begin
      m_x = m_sx / m_area;
      m_y = m_sy / m_area;
    end
  endtask

  // Streams pix, raises vsync (cycle T, k=0) and observes cycles T+1..T+BUDGET.
  // ovr_at > 0 raises a second vsync at T+ovr_at; rst_at >= 0 pulses rst there.
  task automatic run_frame(input int ovr_at, input int rst_at);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          @(negedge clk); de_in = 1'b0; mask = 1'($urandom_range(0, 1));
        end
        @(negedge clk); de_in = 1'b1; mask = pix[r][c];
      end
      @(negedge clk); de_in = 1'b0; mask = 1'b0; h_sync_in = 1'b1;
      @(negedge clk); h_sync_in = 1'b0;
    end
    @(negedge clk); v_sync_in = 1'b1; de_in = 1'b1; mask = 1'b1;
    obs_lat = -1; obs_rv = 0; obs_ovr_k = -1; obs_ovr_n = 0; lat4 = -1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (result_valid) begin
        obs_rv++;
        if (obs_lat < 0) begin
          obs_lat = k; o_x = x; o_y = y; o_area = area; o_found = found;
          o_xmin = x_min; o_xmax = x_max; o_ymin = y_min; o_ymax = y_max;
        end
      end
      if (result_valid_4 && lat4 < 0) begin
        lat4 = k; found4 = found_4; area4 = int'(area_4);
      end
      if (frame_overrun) begin
        obs_ovr_n++;
        if (obs_ovr_k < 0) obs_ovr_k = k;
      end
      v_sync_in = (k < 3) || (ovr_at > 0 && k >= ovr_at && k < ovr_at + 3);
      de_in = v_sync_in; mask = v_sync_in;
      rst = (k == rst_at);
    end
    end_outs = {x, y, area, x_min, x_max, y_min, y_max, found, result_valid, frame_overrun, 1'b0};
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; mask = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({x, y, area, x_min, x_max, y_min, y_max, found, result_valid, frame_overrun} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0",
        {x, y, area, x_min, x_max, y_min, y_max, found, result_valid, frame_overrun});
    end
    total++;
    if ({area_4, found_4, result_valid_4} !== '0) begin
      bad++; $display("FAIL reset_outputs_min4: got %h want 0", {area_4, found_4, result_valid_4});
    end
  endtask

  task automatic test_single_pixel();
    clear_pix(); pix[3][5] = 1'b1;
    model_frame(); run_frame(0, -1);
    total++;
    if (obs_lat !== LAT_OBJ || obs_rv !== 1) begin
      bad++; $display("FAIL single_latency: got lat=%0d n=%0d want lat=%0d n=1", obs_lat, obs_rv, LAT_OBJ);
    end
    total++;
    if ({o_x, o_y} !== {CW'(5), CW'(3)} || {o_x, o_y} !== {CW'(m_x), CW'(m_y)}) begin
      bad++; $display("FAIL single_xy: got %0d,%0d want 5,3", o_x, o_y);
    end
    total++;
    if ({o_area, o_found} !== {AW'(1), 1'b1} || {o_xmin, o_xmax, o_ymin, o_ymax} !== {CW'(5), CW'(5), CW'(3), CW'(3)}) begin
      bad++; $display("FAIL single_area_bbox: got a=%0d f=%0d bb=%0d..%0d/%0d..%0d want 1,1,5..5/3..3",
        o_area, o_found, o_xmin, o_xmax, o_ymin, o_ymax);
    end
  endtask

  task automatic test_block();
    clear_pix();
    for (int r = 20; r <= 21; r++) for (int c = 10; c <= 11; c++) pix[r][c] = 1'b1;
    model_frame(); run_frame(0, -1);
    total++;
    if ({o_x, o_y, o_area} !== {CW'(m_x), CW'(m_y), AW'(m_area)}) begin
      bad++; $display("FAIL block_xy_area: got %0d,%0d,%0d want %0d,%0d,%0d", o_x, o_y, o_area, m_x, m_y, m_area);
    end
    total++;
    if ({o_xmin, o_xmax, o_ymin, o_ymax} !== {CW'(m_xmin), CW'(m_xmax), CW'(m_ymin), CW'(m_ymax)}) begin
      bad++; $display("FAIL block_bbox: got %0d..%0d/%0d..%0d want %0d..%0d/%0d..%0d",
        o_xmin, o_xmax, o_ymin, o_ymax, m_xmin, m_xmax, m_ymin, m_ymax);
    end
  endtask

  task automatic test_full_frame();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 1'b1;
    model_frame(); run_frame(0, -1);
    total++;
    if ({o_x, o_y, o_area, o_found} !== {CW'(m_x), CW'(m_y), AW'(m_area), 1'b1} || obs_lat !== LAT_OBJ) begin
      bad++; $display("FAIL full_frame: got x=%0d y=%0d a=%0d lat=%0d want %0d,%0d,%0d,%0d",
        o_x, o_y, o_area, obs_lat, m_x, m_y, m_area, LAT_OBJ);
    end
    total++;
    if ({o_xmin, o_xmax, o_ymin, o_ymax} !== {CW'(0), CW'(W - 1), CW'(0), CW'(H - 1)}) begin
      bad++; $display("FAIL full_bbox: got %0d..%0d/%0d..%0d want 0..63/0..63", o_xmin, o_xmax, o_ymin, o_ymax);
    end
  endtask

  task automatic test_empty_after_object();
    clear_pix(); model_frame(); run_frame(0, -1);
    total++;
    if (obs_lat !== LAT_EMPTY || obs_rv !== 1) begin
      bad++; $display("FAIL empty_latency: got lat=%0d n=%0d want %0d,1", obs_lat, obs_rv, LAT_EMPTY);
    end
    total++;
    if ({o_found, o_area, o_xmin, o_xmax, o_ymin, o_ymax} !== '0) begin
      bad++; $display("FAIL empty_area_bbox: got f=%0d a=%0d bb=%0d..%0d/%0d..%0d want all 0",
        o_found, o_area, o_xmin, o_xmax, o_ymin, o_ymax);
    end
    total++;
    if ({o_x, o_y} !== {CW'(m_x), CW'(m_y)}) begin
      bad++; $display("FAIL empty_hold_xy: got %0d,%0d want %0d,%0d", o_x, o_y, m_x, m_y);
    end
  endtask

  task automatic test_min_area();
    clear_pix(); pix[7][2] = 1'b1; pix[40][9] = 1'b1; pix[63][63] = 1'b1;
    model_frame(); run_frame(0, -1);
    total++;
    if (lat4 !== LAT_EMPTY || found4 !== 1'b0 || area4 !== 3) begin
      bad++; $display("FAIL min_area_gate: got lat=%0d f=%0d a=%0d want %0d,0,3", lat4, found4, area4, LAT_EMPTY);
    end
    total++;
    if (obs_lat !== LAT_OBJ || {o_x, o_y, o_found} !== {CW'(m_x), CW'(m_y), 1'b1}) begin
      bad++; $display("FAIL min_area_main: got lat=%0d x=%0d y=%0d want %0d,%0d,%0d", obs_lat, o_x, o_y, LAT_OBJ, m_x, m_y);
    end
  endtask

  task automatic test_random(input int n);
    for (int f = 0; f < n; f++) begin
      int dens;
      dens = (f == 0) ? 1 : int'($urandom_range(0, 60));
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) pix[r][c] = ($urandom_range(0, 199) < dens);
      model_frame(); run_frame(0, -1);
      total++;
      if (obs_lat !== (m_found ? LAT_OBJ : LAT_EMPTY) || obs_rv !== 1 || obs_ovr_n !== 0) begin
        bad++; $display("FAIL rand%0d_timing: got lat=%0d n=%0d ovr=%0d want lat=%0d n=1 ovr=0",
          f, obs_lat, obs_rv, obs_ovr_n, m_found ? LAT_OBJ : LAT_EMPTY);
      end
      total++;
      if ({o_x, o_y, o_area, o_found} !== {CW'(m_x), CW'(m_y), AW'(m_area), m_found}) begin
        bad++; $display("FAIL rand%0d_result: got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d",
          f, o_x, o_y, o_area, o_found, m_x, m_y, m_area, m_found);
      end
      total++;
      if ({o_xmin, o_xmax, o_ymin, o_ymax} !== {CW'(m_xmin), CW'(m_xmax), CW'(m_ymin), CW'(m_ymax)}) begin
        bad++; $display("FAIL rand%0d_bbox: got %0d..%0d/%0d..%0d want %0d..%0d/%0d..%0d",
          f, o_xmin, o_xmax, o_ymin, o_ymax, m_xmin, m_xmax, m_ymin, m_ymax);
      end
    end
  endtask

  task automatic test_overrun();
    clear_pix();
    for (int r = 30; r <= 36; r++) for (int c = 12; c <= 20; c++) pix[r][c] = 1'b1;
    model_frame(); run_frame(10, -1);
    total++;
    if (obs_ovr_k !== 11 || obs_ovr_n !== 1) begin
      bad++; $display("FAIL overrun_pulse: got k=%0d n=%0d want 11,1", obs_ovr_k, obs_ovr_n);
    end
    total++;
    if (obs_lat !== LAT_OBJ || obs_rv !== 1) begin
      bad++; $display("FAIL overrun_result: got lat=%0d n=%0d want %0d,1", obs_lat, obs_rv, LAT_OBJ);
    end
    total++;
    if ({o_x, o_y, o_area} !== {CW'(m_x), CW'(m_y), AW'(m_area)}) begin
      bad++; $display("FAIL overrun_values: got %0d,%0d,%0d want %0d,%0d,%0d", o_x, o_y, o_area, m_x, m_y, m_area);
    end
  endtask

  task automatic test_rst_mid_frame();
    clear_pix(); pix[50][50] = 1'b1; pix[51][52] = 1'b1;
    model_frame(); run_frame(0, 15);
    m_x = 0; m_y = 0;
    total++;
    if (obs_rv !== 0) begin
      bad++; $display("FAIL rst_no_result: got %0d strobes want 0", obs_rv);
    end
    total++;
    if (end_outs !== '0) begin
      bad++; $display("FAIL rst_outputs: got %h want 0", end_outs);
    end
    test_random(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_pixel();
    test_block();
    test_full_frame();
    test_empty_after_object();
    test_min_area();
    test_random(3);
    test_overrun();
    test_rst_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
